// File: rtl/store_write_responder.sv
// store_write_responder: store-issue responder; cache hits write the data array, MMIO goes through a one-outstanding FSM.
// Optional STORE_RESP_PERF_EN adds 32-bit hit/miss/MMIO ack counters.
module store_write_responder #(
    parameter  int NUM_EVICTED = 4,
    parameter  int NONCE_W     = 2,
    parameter  int LINE_W      = 128,
    parameter  int WAYS        = 4,
    localparam int ID_W        = $clog2(NUM_EVICTED),
    localparam int WAY_W       = $clog2(WAYS),
    localparam int MASK_W      = LINE_W / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_uopSt_valid,
    input  logic [ID_W-1:0]    IN_uopSt_id,
    input  logic [NONCE_W-1:0] IN_uopSt_nonce,
    input  logic [31:0]        IN_uopSt_addr,
    input  logic [LINE_W-1:0]  IN_uopSt_data,
    input  logic [MASK_W-1:0]  IN_uopSt_wmask,
    input  logic               IN_uopSt_isMMIO,
    output logic               OUT_stallSt,
    input  logic               IN_cacheBusy,
    output logic               OUT_tagReq_valid,
    output logic [31:0]        OUT_tagReq_addr,
    input  logic               IN_tagHit,
    input  logic [WAY_W-1:0]   IN_tagWay,
    output logic               OUT_dataWr_valid,
    output logic [31:0]        OUT_dataWr_addr,
    output logic [WAY_W-1:0]   OUT_dataWr_way,
    output logic [LINE_W-1:0]  OUT_dataWr_data,
    output logic [MASK_W-1:0]  OUT_dataWr_wmask,
    output logic               OUT_missReq_valid,
    output logic [31:0]        OUT_missReq_addr,
    output logic               OUT_mmio_valid,
    input  logic               IN_mmio_ready,
    output logic [31:0]        OUT_mmio_addr,
    output logic [LINE_W-1:0]  OUT_mmio_data,
    output logic [MASK_W-1:0]  OUT_mmio_wmask,
    input  logic               IN_mmio_done,
    input  logic               IN_mmio_err,
    output logic               OUT_stAck_valid,
    output logic [ID_W-1:0]    OUT_stAck_idx,
    output logic [NONCE_W-1:0] OUT_stAck_nonce,
    output logic               OUT_stAck_fail,
    output logic               OUT_busErr
`ifdef STORE_RESP_PERF_EN
   ,output logic [31:0]        OUT_perfHits,
    output logic [31:0]        OUT_perfMisses,
    output logic [31:0]        OUT_perfMmio
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q, state_d;
    logic               s1_valid_q, s1_mmio_q;
    logic [ID_W-1:0]    s1_id_q, m_id_q;
    logic [NONCE_W-1:0] s1_nonce_q, m_nonce_q;
    logic [31:0]        s1_addr_q, m_addr_q;
    logic [LINE_W-1:0]  s1_data_q, m_data_q;
    logic [MASK_W-1:0]  s1_mask_q, m_mask_q;
    logic               ack_valid_q, ack_fail_q, bus_err_q;
    logic [ID_W-1:0]    ack_idx_q;
    logic [NONCE_W-1:0] ack_nonce_q;
    logic               accept, cache_ack, mmio_start, mmio_fin;

    // Tag request is gated by reset so no lookup escapes while rst is asserted.
    assign OUT_stallSt      = IN_cacheBusy | (s1_valid_q & s1_mmio_q) | (state_q != IDLE);
    assign accept           = rst & IN_uopSt_valid & ~OUT_stallSt;
    assign OUT_tagReq_valid = accept & ~IN_uopSt_isMMIO;
    assign OUT_tagReq_addr  = IN_uopSt_addr;
    assign cache_ack        = s1_valid_q & ~s1_mmio_q;
    assign mmio_start       = s1_valid_q & s1_mmio_q;

    assign OUT_dataWr_valid  = cache_ack & IN_tagHit;
    assign OUT_dataWr_addr   = s1_addr_q;
    assign OUT_dataWr_way    = IN_tagWay;
    assign OUT_dataWr_data   = s1_data_q;
    assign OUT_dataWr_wmask  = s1_mask_q;
    assign OUT_missReq_valid = cache_ack & ~IN_tagHit;
    assign OUT_missReq_addr  = s1_addr_q;

    assign OUT_mmio_addr  = m_addr_q;
    assign OUT_mmio_data  = m_data_q;
    assign OUT_mmio_wmask = m_mask_q;

    assign OUT_stAck_valid = ack_valid_q;
    assign OUT_stAck_idx   = ack_idx_q;
    assign OUT_stAck_nonce = ack_nonce_q;
    assign OUT_stAck_fail  = ack_fail_q;
    assign OUT_busErr      = bus_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = mmio_start ? REQ : IDLE;
            REQ:     state_d = IN_mmio_ready ? (IN_mmio_done ? IDLE : RESP) : REQ;
            RESP:    state_d = IN_mmio_done ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle ready+done in REQ completes the write without visiting RESP.
    always_comb begin
        OUT_mmio_valid = state_q == REQ;
        mmio_fin       = IN_mmio_done & ((state_q == RESP) | ((state_q == REQ) & IN_mmio_ready));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            ack_valid_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= accept;
            ack_valid_q <= cache_ack | mmio_fin;
            bus_err_q   <= mmio_fin & IN_mmio_err;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_mmio_q  <= IN_uopSt_isMMIO;
            s1_id_q    <= IN_uopSt_id;
            s1_nonce_q <= IN_uopSt_nonce;
            s1_addr_q  <= IN_uopSt_addr;
            s1_data_q  <= IN_uopSt_data;
            s1_mask_q  <= IN_uopSt_wmask;
        end
        if (mmio_start && state_q == IDLE) begin
            m_id_q    <= s1_id_q;
            m_nonce_q <= s1_nonce_q;
            m_addr_q  <= s1_addr_q;
            m_data_q  <= s1_data_q;
            m_mask_q  <= s1_mask_q;
        end
        ack_idx_q   <= mmio_fin ? m_id_q : s1_id_q;
        ack_nonce_q <= mmio_fin ? m_nonce_q : s1_nonce_q;
        ack_fail_q  <= ~mmio_fin & ~IN_tagHit;
    end

`ifdef STORE_RESP_PERF_EN
    logic [31:0] hits_q, misses_q, mmio_q;

    assign OUT_perfHits   = hits_q;
    assign OUT_perfMisses = misses_q;
    assign OUT_perfMmio   = mmio_q;

    // Counted when the ack is registered, so each counter moves with its ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= 32'd0;
            misses_q <= 32'd0;
            mmio_q   <= 32'd0;
        end else begin
            hits_q   <= hits_q + {31'd0, cache_ack & IN_tagHit};
            misses_q <= misses_q + {31'd0, cache_ack & ~IN_tagHit};
            mmio_q   <= mmio_q + {31'd0, mmio_fin};
        end
    end
`endif
endmodule

// File: tb/tb_store_write_responder.sv
// tb_store_write_responder: directed scenario tasks for store_write_responder.
module tb_store_write_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic         IN_uopSt_valid, IN_uopSt_isMMIO, IN_cacheBusy, IN_tagHit;
    logic [1:0]   IN_uopSt_id, IN_uopSt_nonce, IN_tagWay;
    logic [31:0]  IN_uopSt_addr;
    logic [127:0] IN_uopSt_data;
    logic [15:0]  IN_uopSt_wmask;
    logic         IN_mmio_ready, IN_mmio_done, IN_mmio_err;
    logic         OUT_stallSt, OUT_tagReq_valid, OUT_dataWr_valid, OUT_missReq_valid, OUT_mmio_valid;
    logic [31:0]  OUT_tagReq_addr, OUT_dataWr_addr, OUT_missReq_addr, OUT_mmio_addr;
    logic [1:0]   OUT_dataWr_way, OUT_stAck_idx, OUT_stAck_nonce;
    logic [127:0] OUT_dataWr_data, OUT_mmio_data;
    logic [15:0]  OUT_dataWr_wmask, OUT_mmio_wmask;
    logic         OUT_stAck_valid, OUT_stAck_fail, OUT_busErr;
    int errors = 0;
    int checks = 0;

    store_write_responder dut (
        .clk(clk), .rst(rst),
        .IN_uopSt_valid(IN_uopSt_valid), .IN_uopSt_id(IN_uopSt_id), .IN_uopSt_nonce(IN_uopSt_nonce),
        .IN_uopSt_addr(IN_uopSt_addr), .IN_uopSt_data(IN_uopSt_data), .IN_uopSt_wmask(IN_uopSt_wmask),
        .IN_uopSt_isMMIO(IN_uopSt_isMMIO), .OUT_stallSt(OUT_stallSt), .IN_cacheBusy(IN_cacheBusy),
        .OUT_tagReq_valid(OUT_tagReq_valid), .OUT_tagReq_addr(OUT_tagReq_addr),
        .IN_tagHit(IN_tagHit), .IN_tagWay(IN_tagWay),
        .OUT_dataWr_valid(OUT_dataWr_valid), .OUT_dataWr_addr(OUT_dataWr_addr), .OUT_dataWr_way(OUT_dataWr_way),
        .OUT_dataWr_data(OUT_dataWr_data), .OUT_dataWr_wmask(OUT_dataWr_wmask),
        .OUT_missReq_valid(OUT_missReq_valid), .OUT_missReq_addr(OUT_missReq_addr),
        .OUT_mmio_valid(OUT_mmio_valid), .IN_mmio_ready(IN_mmio_ready), .OUT_mmio_addr(OUT_mmio_addr),
        .OUT_mmio_data(OUT_mmio_data), .OUT_mmio_wmask(OUT_mmio_wmask),
        .IN_mmio_done(IN_mmio_done), .IN_mmio_err(IN_mmio_err),
        .OUT_stAck_valid(OUT_stAck_valid), .OUT_stAck_idx(OUT_stAck_idx), .OUT_stAck_nonce(OUT_stAck_nonce),
        .OUT_stAck_fail(OUT_stAck_fail), .OUT_busErr(OUT_busErr)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [1:0] id, input logic [1:0] nonce,
                            input logic [31:0] addr, input logic [15:0] mask, input logic mmio);
        IN_uopSt_valid  = v;
        IN_uopSt_id     = id;
        IN_uopSt_nonce  = nonce;
        IN_uopSt_addr   = addr;
        IN_uopSt_data   = {4{addr}};
        IN_uopSt_wmask  = mask;
        IN_uopSt_isMMIO = mmio;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        IN_cacheBusy = 1'b0; IN_tagHit = 1'b0; IN_tagWay = 2'd0;
        IN_mmio_ready = 1'b0; IN_mmio_done = 1'b0; IN_mmio_err = 1'b0;
        drive_op(1'b1, 2'd0, 2'd0, 32'h0, 16'hFFFF, 1'b0);
        tick(); tick();
        #1;
        checks++; if (OUT_stAck_valid !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", OUT_stAck_valid); end
        checks++; if (OUT_mmio_valid !== 1'b0) begin errors++; $display("FAIL reset_mmio_valid: got %b expected 0", OUT_mmio_valid); end
        checks++; if (OUT_busErr !== 1'b0) begin errors++; $display("FAIL reset_busErr: got %b expected 0", OUT_busErr); end
        checks++; if (OUT_tagReq_valid !== 1'b0) begin errors++; $display("FAIL reset_tagReq: got %b expected 0", OUT_tagReq_valid); end
        checks++; if (OUT_dataWr_valid !== 1'b0 || OUT_missReq_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_miss: got %b%b expected 00", OUT_dataWr_valid, OUT_missReq_valid); end
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        drive_op(1'b1, 2'd2, 2'd1, 32'h1000, 16'h000F, 1'b0);
        #1;
        checks++; if (OUT_stallSt !== 1'b0) begin errors++; $display("FAIL hit_stall: got %b expected 0", OUT_stallSt); end
        checks++; if (OUT_tagReq_valid !== 1'b1 || OUT_tagReq_addr !== 32'h1000) begin errors++; $display("FAIL hit_tagReq: got %b/%h expected 1/00001000", OUT_tagReq_valid, OUT_tagReq_addr); end
        tick();
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        IN_tagHit = 1'b1; IN_tagWay = 2'd3;
        #1;
        checks++; if (OUT_dataWr_valid !== 1'b1 || OUT_dataWr_way !== 2'd3 || OUT_dataWr_wmask !== 16'h000F) begin errors++; $display("FAIL hit_dataWr: got v=%b way=%0d mask=%h expected v=1 way=3 mask=000f", OUT_dataWr_valid, OUT_dataWr_way, OUT_dataWr_wmask); end
        checks++; if (OUT_dataWr_addr !== 32'h1000 || OUT_dataWr_data !== {4{32'h1000}}) begin errors++; $display("FAIL hit_dataWr_payload: got %h/%h expected 00001000/%h", OUT_dataWr_addr, OUT_dataWr_data, {4{32'h1000}}); end
        checks++; if (OUT_missReq_valid !== 1'b0 || OUT_stAck_valid !== 1'b0) begin errors++; $display("FAIL hit_early: got miss=%b ack=%b expected 0/0", OUT_missReq_valid, OUT_stAck_valid); end
        tick();
        IN_tagHit = 1'b0;
        #1;
        checks++; if (OUT_stAck_valid !== 1'b1 || OUT_stAck_idx !== 2'd2 || OUT_stAck_nonce !== 2'd1 || OUT_stAck_fail !== 1'b0) begin errors++; $display("FAIL hit_ack: got v=%b idx=%0d nonce=%0d fail=%b expected 1/2/1/0", OUT_stAck_valid, OUT_stAck_idx, OUT_stAck_nonce, OUT_stAck_fail); end
        tick();
        checks++; if (OUT_stAck_valid !== 1'b0) begin errors++; $display("FAIL hit_ack_once: got %b expected 0", OUT_stAck_valid); end
    endtask

    task automatic test_miss();
        drive_op(1'b1, 2'd1, 2'd3, 32'h2040, 16'hFFFF, 1'b0);
        tick();
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        IN_tagHit = 1'b0;
        #1;
        checks++; if (OUT_missReq_valid !== 1'b1 || OUT_missReq_addr !== 32'h2040) begin errors++; $display("FAIL miss_req: got %b/%h expected 1/00002040", OUT_missReq_valid, OUT_missReq_addr); end
        checks++; if (OUT_dataWr_valid !== 1'b0) begin errors++; $display("FAIL miss_no_dataWr: got %b expected 0", OUT_dataWr_valid); end
        tick();
        #1;
        checks++; if (OUT_stAck_valid !== 1'b1 || OUT_stAck_idx !== 2'd1 || OUT_stAck_nonce !== 2'd3 || OUT_stAck_fail !== 1'b1) begin errors++; $display("FAIL miss_ack: got v=%b idx=%0d nonce=%0d fail=%b expected 1/1/3/1", OUT_stAck_valid, OUT_stAck_idx, OUT_stAck_nonce, OUT_stAck_fail); end
        tick();
    endtask

    task automatic test_zero_mask();
        drive_op(1'b1, 2'd3, 2'd0, 32'h3000, 16'h0000, 1'b0);
        tick();
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        IN_tagHit = 1'b1; IN_tagWay = 2'd1;
        #1;
        checks++; if (OUT_dataWr_valid !== 1'b1 || OUT_dataWr_wmask !== 16'h0000) begin errors++; $display("FAIL zmask_dataWr: got %b/%h expected 1/0000", OUT_dataWr_valid, OUT_dataWr_wmask); end
        tick();
        IN_tagHit = 1'b0;
        #1;
        checks++; if (OUT_stAck_valid !== 1'b1 || OUT_stAck_idx !== 2'd3 || OUT_stAck_fail !== 1'b0) begin errors++; $display("FAIL zmask_ack: got v=%b idx=%0d fail=%b expected 1/3/0", OUT_stAck_valid, OUT_stAck_idx, OUT_stAck_fail); end
        tick();
    endtask

    task automatic test_back_to_back();
        IN_tagHit = 1'b1; IN_tagWay = 2'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive_op(1'b1, 2'(i), 2'(3 - i), 32'h4000 + 32'(i * 16), 16'hFFFF, 1'b0);
            else       drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
            #1;
            if (i < 4) begin
                checks++; if (OUT_stallSt !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected 0", i, OUT_stallSt); end
            end
            if (i >= 2) begin
                checks++; if (OUT_stAck_valid !== 1'b1 || OUT_stAck_idx !== 2'(i - 2) || OUT_stAck_nonce !== 2'(5 - i)) begin errors++; $display("FAIL b2b_ack[%0d]: got v=%b idx=%0d nonce=%0d expected 1/%0d/%0d", i, OUT_stAck_valid, OUT_stAck_idx, OUT_stAck_nonce, i - 2, 5 - i); end
            end
            tick();
        end
        IN_tagHit = 1'b0;
        tick();
    endtask

    task automatic test_mmio();
        drive_op(1'b1, 2'd1, 2'd2, 32'h1000_0000, 16'h00FF, 1'b1);
        #1;
        checks++; if (OUT_tagReq_valid !== 1'b0 || OUT_stallSt !== 1'b0) begin errors++; $display("FAIL mmio_accept: got tagReq=%b stall=%b expected 0/0", OUT_tagReq_valid, OUT_stallSt); end
        tick();
        drive_op(1'b1, 2'd0, 2'd0, 32'h5000, 16'hFFFF, 1'b0);
        #1;
        checks++; if (OUT_stallSt !== 1'b1 || OUT_tagReq_valid !== 1'b0) begin errors++; $display("FAIL mmio_s1_stall: got stall=%b tagReq=%b expected 1/0", OUT_stallSt, OUT_tagReq_valid); end
        tick();
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            IN_mmio_ready = (i == 2);
            #1;
            checks++; if (OUT_mmio_valid !== 1'b1 || OUT_mmio_addr !== 32'h1000_0000 || OUT_mmio_wmask !== 16'h00FF || OUT_stallSt !== 1'b1) begin errors++; $display("FAIL mmio_req[%0d]: got v=%b addr=%h mask=%h stall=%b expected 1/10000000/00ff/1", i, OUT_mmio_valid, OUT_mmio_addr, OUT_mmio_wmask, OUT_stallSt); end
            tick();
        end
        IN_mmio_ready = 1'b0;
        #1;
        checks++; if (OUT_mmio_valid !== 1'b0 || OUT_stallSt !== 1'b1 || OUT_stAck_valid !== 1'b0) begin errors++; $display("FAIL mmio_resp_wait: got v=%b stall=%b ack=%b expected 0/1/0", OUT_mmio_valid, OUT_stallSt, OUT_stAck_valid); end
        tick();
        IN_mmio_done = 1'b1; IN_mmio_err = 1'b1;
        #1;
        checks++; if (OUT_stallSt !== 1'b1 || OUT_stAck_valid !== 1'b0) begin errors++; $display("FAIL mmio_done_cycle: got stall=%b ack=%b expected 1/0", OUT_stallSt, OUT_stAck_valid); end
        tick();
        IN_mmio_done = 1'b0; IN_mmio_err = 1'b0;
        #1;
        checks++; if (OUT_stAck_valid !== 1'b1 || OUT_stAck_idx !== 2'd1 || OUT_stAck_nonce !== 2'd2 || OUT_stAck_fail !== 1'b0) begin errors++; $display("FAIL mmio_ack: got v=%b idx=%0d nonce=%0d fail=%b expected 1/1/2/0", OUT_stAck_valid, OUT_stAck_idx, OUT_stAck_nonce, OUT_stAck_fail); end
        checks++; if (OUT_busErr !== 1'b1 || OUT_stallSt !== 1'b0) begin errors++; $display("FAIL mmio_busErr: got err=%b stall=%b expected 1/0", OUT_busErr, OUT_stallSt); end
        tick();
        checks++; if (OUT_busErr !== 1'b0 || OUT_stAck_valid !== 1'b0) begin errors++; $display("FAIL mmio_pulse_end: got err=%b ack=%b expected 0/0", OUT_busErr, OUT_stAck_valid); end
    endtask

    task automatic test_mmio_fast();
        drive_op(1'b1, 2'd3, 2'd3, 32'h1000_0010, 16'hFFFF, 1'b1);
        tick();
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        tick();
        IN_mmio_ready = 1'b1; IN_mmio_done = 1'b1; IN_mmio_err = 1'b0;
        #1;
        checks++; if (OUT_mmio_valid !== 1'b1) begin errors++; $display("FAIL fast_req: got %b expected 1", OUT_mmio_valid); end
        tick();
        IN_mmio_ready = 1'b0; IN_mmio_done = 1'b0;
        #1;
        checks++; if (OUT_stAck_valid !== 1'b1 || OUT_stAck_idx !== 2'd3 || OUT_stAck_fail !== 1'b0 || OUT_busErr !== 1'b0 || OUT_stallSt !== 1'b0) begin errors++; $display("FAIL fast_ack: got v=%b idx=%0d fail=%b err=%b stall=%b expected 1/3/0/0/0", OUT_stAck_valid, OUT_stAck_idx, OUT_stAck_fail, OUT_busErr, OUT_stallSt); end
        tick();
    endtask

    task automatic test_cache_busy();
        IN_cacheBusy = 1'b1;
        drive_op(1'b1, 2'd2, 2'd2, 32'h6000, 16'hFFFF, 1'b0);
        #1;
        checks++; if (OUT_stallSt !== 1'b1 || OUT_tagReq_valid !== 1'b0) begin errors++; $display("FAIL busy_stall: got stall=%b tagReq=%b expected 1/0", OUT_stallSt, OUT_tagReq_valid); end
        tick();
        IN_cacheBusy = 1'b0; IN_tagHit = 1'b1;
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        #1;
        checks++; if (OUT_dataWr_valid !== 1'b0 || OUT_missReq_valid !== 1'b0) begin errors++; $display("FAIL busy_no_s1: got wr=%b miss=%b expected 0/0", OUT_dataWr_valid, OUT_missReq_valid); end
        tick();
        IN_tagHit = 1'b0;
        checks++; if (OUT_stAck_valid !== 1'b0) begin errors++; $display("FAIL busy_no_ack: got %b expected 0", OUT_stAck_valid); end
        tick();
    endtask

    task automatic test_reset_in_resp();
        drive_op(1'b1, 2'd2, 2'd1, 32'h1000_0020, 16'hFFFF, 1'b1);
        tick();
        drive_op(1'b0, 2'd0, 2'd0, 32'h0, 16'h0, 1'b0);
        tick();
        IN_mmio_ready = 1'b1;
        tick();
        IN_mmio_ready = 1'b0;
        #1;
        checks++; if (OUT_stallSt !== 1'b1 || OUT_mmio_valid !== 1'b0) begin errors++; $display("FAIL rresp_in_resp: got stall=%b v=%b expected 1/0", OUT_stallSt, OUT_mmio_valid); end
        rst = 1'b0;
        #1;
        checks++; if (OUT_stAck_valid !== 1'b0 || OUT_busErr !== 1'b0 || OUT_mmio_valid !== 1'b0) begin errors++; $display("FAIL rresp_async: got ack=%b err=%b v=%b expected 0/0/0", OUT_stAck_valid, OUT_busErr, OUT_mmio_valid); end
        tick();
        rst = 1'b1;
        IN_mmio_done = 1'b1; IN_mmio_err = 1'b1;
        #1;
        checks++; if (OUT_stallSt !== 1'b0) begin errors++; $display("FAIL rresp_idle: got stall=%b expected 0", OUT_stallSt); end
        tick();
        IN_mmio_done = 1'b0; IN_mmio_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (OUT_stAck_valid !== 1'b0 || OUT_busErr !== 1'b0) begin errors++; $display("FAIL rresp_no_ack[%0d]: got ack=%b err=%b expected 0/0", i, OUT_stAck_valid, OUT_busErr); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_zero_mask();
        test_back_to_back();
        test_mmio();
        test_mmio_fast();
        test_cache_busy();
        test_reset_in_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
